// File: rtl/card_row_sampler.sv
// card_row_sampler
//
// Samples the read-brush column lines on each of the twelve row-timing pulses
// (sccb) of a clutch cycle and assembles a Hollerith image per card. A rising
// edge on the cycle-end cam (rl10) closes the frame. Completed cards sit in one
// of two image buffers and are drained one column per valid/ready transfer,
// oldest card first.
//
// Ports:
//   clk, rst_n            model clock (one tick per shaft degree), async active-low reset
//   sccb                  row-timing pulse, rising edge = one row strobe
//   rl10                  cycle-end cam, rising edge = frame close
//   brush[COLS-1:0]       brush contact per column, 1 = hole
//   col_valid/col_ready   column handshake toward the translation logic
//   col_data[11:0]        bits 0-9 digits 0-9, bit 10 = 11-zone, bit 11 = 12-zone
//   col_index, col_last   current column number, last-column flag
//   overrun               one-clock pulse: a completed frame was dropped
//   row_err               one-clock pulse: frame closed with row count != 12
//
// Build option: define ROW_COUNT_CHECK_EN to reject frames whose row count is
// not exactly 12 (row_err pulse, frame discarded). Without it row_err stays 0
// and every frame that finds buffer space is accepted.
//
// Buffer policy: a frame is accepted whenever the buffer it was written into
// is not already holding an undrained card. If the other buffer is still busy
// the fill pointer stays on the freshly completed buffer until the drain
// releases the other one; rows strobed meanwhile cannot be stored, so such a
// frame is reported as an overrun when it closes.

module card_row_sampler #(
    parameter int COLS = 80,
    parameter int IDXW = $clog2(COLS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sccb,
    input  logic            rl10,
    input  logic [COLS-1:0] brush,
    output logic            col_valid,
    input  logic            col_ready,
    output logic [11:0]     col_data,
    output logic [IDXW-1:0] col_index,
    output logic            col_last,
    output logic            overrun,
    output logic            row_err
);

    typedef enum logic {ST_EMPTY = 1'b0, ST_SEND = 1'b1} drain_st_t;

    logic            sccb_q_r;
    logic            rl10_q_r;
    logic [3:0]      row_cnt_r;
    logic [11:0]     img_r [2][COLS];
    logic [1:0]      full_r;
    logic            fill_sel_r;
    logic            drain_sel_r;
    logic            lost_r;
    drain_st_t       state_r;

    logic            strobe_s;
    logic            close_s;
    logic [3:0]      cnt_next_s;
    logic [3:0]      row_pos_s;
    logic            row_wr_s;
    logic            rows_ok_s;
    logic            accept_s;
    logic            ovr_s;
    logic            rerr_s;
    logic            done_s;
    logic            fill_stuck_s;
    logic [IDXW-1:0] nxt_idx_s;
    logic [11:0]     fill_img_s [COLS];

    // Rows arrive 9-edge first: strobes 0..9 are digits 9..0, then 11, then 12.
    function automatic logic [3:0] row_bit(input logic [3:0] k);
        case (k)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
            4'd5, 4'd6, 4'd7, 4'd8, 4'd9: row_bit = 4'd9 - k;
            4'd10:                        row_bit = 4'd10;
            4'd11:                        row_bit = 4'd11;
            default:                      row_bit = 4'd0;
        endcase
    endfunction

    assign strobe_s   = sccb & ~sccb_q_r;
    assign close_s    = rl10 & ~rl10_q_r;
    assign cnt_next_s = (strobe_s && row_cnt_r != 4'd15) ? row_cnt_r + 4'd1 : row_cnt_r;
    assign row_pos_s  = row_bit(row_cnt_r);
    assign row_wr_s   = strobe_s & (row_cnt_r < 4'd12) & ~full_r[fill_sel_r];

`ifdef ROW_COUNT_CHECK_EN
    assign rows_ok_s = (cnt_next_s == 4'd12);
`else
    assign rows_ok_s = 1'b1;
`endif

    // lost_r marks a frame that had rows strobed while it had nowhere to go.
    assign accept_s     = close_s & rows_ok_s & ~full_r[fill_sel_r] & ~lost_r;
    assign ovr_s        = close_s & rows_ok_s & ~accept_s;
    assign rerr_s       = close_s & ~rows_ok_s;
    assign done_s       = (state_r == ST_SEND) & col_ready & col_last;
    assign fill_stuck_s = full_r[fill_sel_r] | (accept_s & full_r[~fill_sel_r]);
    assign nxt_idx_s    = col_index + IDXW'(1);

    // Fill-buffer image with the current row merged in, so a row strobed in
    // the close clock is part of the frame and of the first column presented.
    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            fill_img_s[c]            = img_r[fill_sel_r][c];
            fill_img_s[c][row_pos_s] = row_wr_s ? brush[c] : img_r[fill_sel_r][c][row_pos_s];
        end
    end

    // Edge detectors, row counter, image buffers, full flags and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sccb_q_r   <= 1'b0;
            rl10_q_r   <= 1'b0;
            row_cnt_r  <= 4'd0;
            full_r     <= 2'b00;
            fill_sel_r <= 1'b0;
            lost_r     <= 1'b0;
            overrun    <= 1'b0;
            row_err    <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < COLS; c++) begin
                    img_r[b][c] <= 12'h000;
                end
            end
        end else begin
            sccb_q_r <= sccb;
            rl10_q_r <= rl10;
            overrun  <= ovr_s;
            row_err  <= rerr_s;
            if (row_wr_s) begin
                for (int c = 0; c < COLS; c++) begin
                    img_r[fill_sel_r][c] <= fill_img_s[c];
                end
            end
            if (close_s) begin
                row_cnt_r <= 4'd0;
                lost_r    <= 1'b0;
                if (accept_s) begin
                    full_r[fill_sel_r] <= 1'b1;
                    if (!full_r[~fill_sel_r]) begin
                        fill_sel_r <= ~fill_sel_r;
                        for (int c = 0; c < COLS; c++) begin
                            img_r[~fill_sel_r][c] <= 12'h000;
                        end
                    end
                end else if (!full_r[fill_sel_r]) begin
                    // Discarded frame: wipe the partial image, keep the pointer.
                    for (int c = 0; c < COLS; c++) begin
                        img_r[fill_sel_r][c] <= 12'h000;
                    end
                end
            end else begin
                row_cnt_r <= cnt_next_s;
                if (strobe_s && full_r[fill_sel_r]) begin
                    lost_r <= 1'b1;
                end
            end
            if (done_s) begin
                full_r[drain_sel_r] <= 1'b0;
                // Fill pointer parked on a full buffer moves to the one just freed.
                if (fill_stuck_s) begin
                    fill_sel_r <= drain_sel_r;
                    for (int c = 0; c < COLS; c++) begin
                        img_r[drain_sel_r][c] <= 12'h000;
                    end
                end
            end
        end
    end

    // Drain FSM: presents one column per handshake, oldest card first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            drain_sel_r <= 1'b0;
            col_valid   <= 1'b0;
            col_data    <= 12'h000;
            col_index   <= '0;
            col_last    <= 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_r     <= ST_SEND;
                        drain_sel_r <= fill_sel_r;
                        col_valid   <= 1'b1;
                        col_data    <= fill_img_s[0];
                        col_index   <= '0;
                        col_last    <= (COLS == 1);
                    end
                end
                ST_SEND: begin
                    if (col_ready) begin
                        if (!col_last) begin
                            col_index <= nxt_idx_s;
                            col_data  <= img_r[drain_sel_r][nxt_idx_s];
                            col_last  <= (nxt_idx_s == IDXW'(COLS - 1));
                        end else if (accept_s && fill_sel_r != drain_sel_r) begin
                            // Other buffer completes in this very clock.
                            drain_sel_r <= fill_sel_r;
                            col_data    <= fill_img_s[0];
                            col_index   <= '0;
                            col_last    <= (COLS == 1);
                        end else if (full_r[~drain_sel_r]) begin
                            drain_sel_r <= ~drain_sel_r;
                            col_data    <= img_r[~drain_sel_r][0];
                            col_index   <= '0;
                            col_last    <= (COLS == 1);
                        end else begin
                            state_r   <= ST_EMPTY;
                            col_valid <= 1'b0;
                            col_data  <= 12'h000;
                            col_index <= '0;
                            col_last  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_EMPTY;
                    col_valid <= 1'b0;
                    col_data  <= 12'h000;
                    col_index <= '0;
                    col_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule
